// File: rtl/uart_rx_sipo.sv
// UART receiver: 2-flop line synchroniser, mid-bit sampling FSM and an LSB-first
// shift register. Output is one byte per good frame, with a pulse on framing errors.
`timescale 1ns/1ps
module uart_rx_sipo #(
  parameter int  CLKS_PER_BIT = 16,
  localparam int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e             state_q, state_d;
  logic               rxd_meta_q, rxd_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q;

  // Sync flops reset to the idle level so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Held at zero so the counter starts from 0 on START entry.
        cnt_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line stuck low after a bad stop bit must not retrigger START.
        cnt_d = '0;
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: a bench serialiser drives rxd, a monitor counts
// output pulses, and one initial block walks through the scenarios in order.
`timescale 1ns/1ps
module tb_uart_rx_sipo;

  localparam int BIT_T = 160;  // 16 clk of 10 ns

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int valid_cnt = 0, valid_hi = 0, ferr_cnt = 0, both_cnt = 0;
  int valid_cyc = 0, busy_cyc = 0;
  logic valid_prev = 1'b0, ferr_prev = 1'b0, busy_prev = 1'b0;

  uart_rx_sipo #(.CLKS_PER_BIT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_hi++;
      if (!valid_prev) begin
        valid_cnt++;
        valid_cyc = cyc;
      end
    end
    if (frame_err && !ferr_prev) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if (busy && !busy_prev) busy_cyc = cyc;
    valid_prev = rx_valid;
    ferr_prev  = frame_err;
    busy_prev  = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Emulates the PISO: start bit, 8 data bits LSB first, then the given stop level.
  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop);
    rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bt);
    end
    rxd = stop;
    #(bt);
  endtask

  initial begin
    int v0, f0, busy_n;
    logic [7:0] part;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0xA5 and latency from START entry
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, BIT_T, 1'b1);
    repeat (4) @(negedge clk);
    chk("a5_pulses", valid_cnt - v0, 32'd1);
    chk("a5_data", {24'd0, rx_data}, 32'hA5);
    chk("a5_no_ferr", ferr_cnt - f0, 32'd0);
    chk("a5_busy_low", {31'd0, busy}, 32'd0);
    chk("a5_latency", valid_cyc - busy_cyc, 32'd152);

    // Back-to-back frames, zero idle gap
    v0 = valid_cnt;
    send_frame(8'h00, BIT_T, 1'b1);
    chk("b2b_data0", {24'd0, rx_data}, 32'h00);
    send_frame(8'hFF, BIT_T, 1'b1);
    chk("b2b_data1", {24'd0, rx_data}, 32'hFF);
    send_frame(8'h81, BIT_T, 1'b1);
    chk("b2b_data2", {24'd0, rx_data}, 32'h81);
    repeat (4) @(negedge clk);
    chk("b2b_pulses", valid_cnt - v0, 32'd3);
    chk("b2b_no_ferr", ferr_cnt - f0, 32'd0);

    // Glitch: 4 clk low, then a real frame
    v0 = valid_cnt;
    busy_n = 0;
    rxd = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i == 4) rxd = 1'b1;
      @(negedge clk);
      busy_n += int'(busy);
    end
    chk("glitch_busy_window", {31'd0, (busy_n >= 1 && busy_n <= 10)}, 32'd1);
    chk("glitch_no_valid", valid_cnt - v0, 32'd0);
    chk("glitch_no_ferr", ferr_cnt - f0, 32'd0);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, BIT_T, 1'b1);
    repeat (4) @(negedge clk);
    chk("glitch_next_data", {24'd0, rx_data}, 32'h3C);
    chk("glitch_next_pulses", valid_cnt - v0, 32'd1);

    // Framing error with the line held low afterwards
    send_frame(8'h11, BIT_T, 1'b1);
    chk("fe_good_data", {24'd0, rx_data}, 32'h11);
    v0 = valid_cnt;
    send_frame(8'h3C, BIT_T, 1'b0);
    repeat (40) @(negedge clk);
    chk("fe_pulses", ferr_cnt - f0, 32'd1);
    chk("fe_no_valid", valid_cnt - v0, 32'd0);
    chk("fe_data_kept", {24'd0, rx_data}, 32'h11);
    chk("fe_busy_in_break", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    chk("fe_busy_released", {31'd0, busy}, 32'd0);

    // Reset in the middle of data bit 3 of 0x5A
    part = 8'h5A;
    rxd = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 3; i++) begin
      rxd = part[i];
      #(BIT_T);
    end
    rxd = part[3];
    #(BIT_T / 2);
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h5A, BIT_T, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_next_data", {24'd0, rx_data}, 32'h5A);
    chk("rst_next_pulses", valid_cnt - v0, 32'd1);

    // Rate tolerance: slow (17 clk) and fast (15.6 clk) bit periods
    v0 = valid_cnt;
    send_frame(8'h96, 170, 1'b1);
    repeat (4) @(negedge clk);
    chk("slow_data", {24'd0, rx_data}, 32'h96);
    chk("slow_pulses", valid_cnt - v0, 32'd1);
    send_frame(8'h69, BIT_T, 1'b1);
    repeat (4) @(negedge clk);
    chk("mid_data", {24'd0, rx_data}, 32'h69);
    send_frame(8'h96, 156, 1'b1);
    repeat (4) @(negedge clk);
    chk("fast_data", {24'd0, rx_data}, 32'h96);
    chk("rate_pulses", valid_cnt - v0, 32'd3);
    chk("rate_no_ferr", ferr_cnt - f0, 32'd0);

    // Pulse shape over the whole run
    chk("valid_one_cycle", valid_hi, valid_cnt);
    chk("never_both", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
